ysyx_25060170_mdu_ctrl: RTL and testbench
=========================================

YSYX_25060170_MDU_CTRL -- requirements
Module: ysyx_25060170_mdu_ctrl
Multi-cycle RV64M sequencer: accepts decoded mul/div/rem ops from EXU, runs shared iterative shift datapath, returns result by handshake.

Interface
REQ-001 clk  in  1  sole clock; all state on rising edge.
REQ-002 rst  in  1  reset; asynchronous, active-low.
REQ-003 in_valid  in  1  op request from EXU.
REQ-004 in_ready  out  1  MDU can accept; high only in IDLE.
REQ-005 in_op  in  4  MDU op code, from shared package (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, MULW, DIVW, DIVUW, REMW, REMUW).
REQ-006 in_src1  in  64  rs1 value / dividend.
REQ-007 in_src2  in  64  rs2 value / divisor.
REQ-008 flush  in  1  abort in-flight op (redirect/exception).
REQ-009 out_valid  out  1  result available.
REQ-010 out_ready  in  1  WB accepts result.
REQ-011 out_result  out  64  result; W ops sign-extended from bit 31.
REQ-012 busy  out  1  high in BUSY or DONE; drives IDU/IFU stall.

Function
REQ-013 FSM states IDLE, BUSY, DONE; encoding in shared package.
REQ-014 IDLE: in_valid & in_ready -> latch op/operands; special case -> DONE, else BUSY, counter = 63 (64-bit) or 31 (W).
REQ-015 BUSY: one shift-add (mul) or restoring shift-subtract (div) step per cycle; counter==0 -> DONE next edge.
REQ-016 Latency accept-edge to first out_valid cycle: 65 cycles 64-bit ops, 33 cycles W ops, 1 cycle special cases.
REQ-017 DONE: out_valid=1, out_result stable; out_valid & out_ready -> IDLE; out_ready low -> hold indefinitely.
REQ-018 No back-to-back accept in same cycle as result retire; next accept earliest the cycle after IDLE entered.
REQ-019 Signed ops: operate on magnitudes, fix sign at DONE entry; MULHSU treats src2 unsigned.
REQ-020 W ops: operands are src[31:0], sign- or zero-extended per op; result bits[63:32] = result[31].
REQ-021 Divide by zero: quotient = all ones (width of op), remainder = dividend; 1-cycle path.
REQ-022 Signed overflow (most-negative / -1): quotient = dividend, remainder = 0; 1-cycle path.
REQ-023 flush in any state -> IDLE next edge, out_valid low next cycle, no result produced; flush has priority over accept and retire in same cycle.
REQ-024 in_op outside package list: ignored, in_ready stays high, no state change.

Reset
REQ-025 rst low -> immediately: state IDLE, counter 0, out_valid 0, out_result 0, busy 0, in_ready 1 after release.
REQ-026 Reset mid-operation discards op; no partial result visible after release.

Configuration
REQ-027 YSYX_25060170_MDU_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU/MULW use single-cycle combinational multiplier, IDLE -> DONE directly, latency 1 cycle; divides unchanged.
REQ-028 Macro undefined: all multiplies use iterative path, latency per REQ-016; no multiplier operator synthesized.

Structure
REQ-029 Shared package / define file: MDU op codes, FSM state encodings, counter width, iteration counts (64, 32).
REQ-030 One sub-module ysyx_25060170_mdu_div_step: combinational one-bit restoring divide step (remainder, quotient, divisor in; next remainder, quotient out); FSM, counter, sign fixup, multiply in top.

Verification
REQ-031 DIV src1=-20 src2=3 -> out_valid exactly 65 cycles after accept, result 0xFFFF_FFFF_FFFF_FFFA (-6); REM same operands -> -2.
REQ-032 DIVU src2=0, src1=0x1234 -> result 0xFFFF_FFFF_FFFF_FFFF one cycle after accept; REMU -> 0x1234.
REQ-033 DIV src1=0x8000_0000_0000_0000 src2=-1 -> result 0x8000_0000_0000_0000 in 1 cycle; DIVW src1=0x8000_0000 src2=-1 -> 0xFFFF_FFFF_8000_0000.
REQ-034 MULHU src1=src2=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE; latency 65 (macro off) or 1 (macro on).
REQ-035 MULW src1=0x7FFF_FFFF src2=2 -> 0xFFFF_FFFF_FFFF_FFFE after 33 cycles; hold out_ready low 5 cycles -> result stable, busy high.
REQ-036 Flush at BUSY cycle 10 of DIV -> IDLE next edge, no out_valid; rst low mid-DIV -> all outputs at reset values immediately.

Source files
------------

// File: rtl/ysyx_25060170_mdu_ctrl_pkg.sv
// Shared definitions for the RV64M multiply/divide unit: op codes, FSM
// state encodings, iteration counter sizing and small decode helpers.
package ysyx_25060170_mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    MDU_MUL    = 4'd0,
    MDU_MULH   = 4'd1,
    MDU_MULHSU = 4'd2,
    MDU_MULHU  = 4'd3,
    MDU_DIV    = 4'd4,
    MDU_DIVU   = 4'd5,
    MDU_REM    = 4'd6,
    MDU_REMU   = 4'd7,
    MDU_MULW   = 4'd8,
    MDU_DIVW   = 4'd9,
    MDU_DIVUW  = 4'd10,
    MDU_REMW   = 4'd11,
    MDU_REMUW  = 4'd12
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  localparam int CNT_W  = 6;
  localparam int ITER_D = 64;
  localparam int ITER_W = 32;

  localparam logic [CNT_W-1:0] CNT_LOAD_D = CNT_W'(ITER_D - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD_W = CNT_W'(ITER_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  function automatic logic op_known(input logic [3:0] op);
    return op <= 4'd12;
  endfunction

  function automatic logic op_is_mul(input logic [3:0] op);
    return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU, MDU_MULW};
  endfunction

  function automatic logic op_is_w(input logic [3:0] op);
    return op inside {MDU_MULW, MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
  endfunction

  function automatic logic op_is_rem(input logic [3:0] op);
    return op inside {MDU_REM, MDU_REMU, MDU_REMW, MDU_REMUW};
  endfunction

  // rs1 is treated as signed
  function automatic logic op_sgn1(input logic [3:0] op);
    return op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM, MDU_DIVW, MDU_REMW};
  endfunction

  // rs2 is treated as signed
  function automatic logic op_sgn2(input logic [3:0] op);
    return op inside {MDU_MULH, MDU_DIV, MDU_REM, MDU_DIVW, MDU_REMW};
  endfunction

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_25060170_mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, shift the quotient bit in.
module ysyx_25060170_mdu_div_step (
  input  logic [63:0] rem_i,
  input  logic [63:0] quo_i,
  input  logic [63:0] dvs_i,
  output logic [63:0] rem_o,
  output logic [63:0] quo_o
);

  logic [64:0] shl;
  logic [64:0] diff;
  logic        ge;

  // Trial subtraction; the partial remainder is always below the divisor so
  // the 65-bit difference never wraps and its top bit is the borrow.
  always_comb begin
    shl   = {rem_i, quo_i[63]};
    diff  = shl - {1'b0, dvs_i};
    ge    = ~diff[64];
    rem_o = ge ? diff[63:0] : shl[63:0];
    quo_o = {quo_i[62:0], ge};
  end

endmodule

// File: rtl/ysyx_25060170_mdu_ctrl.sv
// RV64M multiply/divide sequencer. Operands are reduced to magnitudes, run
// through a shared shift datapath (shift-add for multiply, restoring divide),
// and the sign is restored on entry to DONE. Divide-by-zero and signed
// overflow bypass the datapath. Optional macro YSYX_25060170_MDU_FAST_MUL_EN
// replaces the iterative multiply with a single-cycle combinational one.
module ysyx_25060170_mdu_ctrl
  import ysyx_25060170_mdu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [63:0] in_src1,
  input  logic [63:0] in_src2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic        busy
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      result_q, result_d;
  logic [3:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic [63:0]      hi_q, hi_d;
  logic [63:0]      lo_q, lo_d;
  logic [63:0]      opnd_q, opnd_d;

  // request decode
  logic        req_known, req_mul, req_w, req_rem, req_sgn1, req_sgn2;
  logic [63:0] a_ext, b_ext, a_mag, b_mag, src1_res, spec_res, fast_res;
  logic        a_neg, b_neg, req_neg, div_zero, div_ovf, accept;

  // iteration step results
  logic [63:0] step_hi, step_lo, div_rem, div_quo;
  logic [64:0] mul_sum;

  // Final sign correction and W-result extension applied on DONE entry.
  function automatic logic [63:0] fixup(input logic [3:0] op, input logic neg,
                                        input logic [63:0] hi, input logic [63:0] lo);
    logic [63:0] r;
    logic [31:0] r32;
    r   = '0;
    r32 = '0;
    case (op)
      MDU_MUL:                        r = lo;
      MDU_MULH, MDU_MULHSU, MDU_MULHU: r = neg ? (~hi + {63'd0, lo == 64'd0}) : hi;
      MDU_MULW:                       r = sext32(lo[63:32]);
      MDU_DIV, MDU_DIVU:              r = neg ? -lo : lo;
      MDU_REM, MDU_REMU:              r = neg ? -hi : hi;
      MDU_DIVW, MDU_DIVUW: begin
        r32 = neg ? -lo[31:0] : lo[31:0];
        r   = sext32(r32);
      end
      MDU_REMW, MDU_REMUW: begin
        r32 = neg ? -hi[31:0] : hi[31:0];
        r   = sext32(r32);
      end
      default:                        r = '0;
    endcase
    return r;
  endfunction

  // Decode the incoming request: extended operands, magnitudes, result sign
  // and the bypass cases.
  always_comb begin
    req_known = op_known(in_op);
    req_mul   = op_is_mul(in_op);
    req_w     = op_is_w(in_op);
    req_rem   = op_is_rem(in_op);
    req_sgn1  = op_sgn1(in_op);
    req_sgn2  = op_sgn2(in_op);
    a_ext     = req_w ? (req_sgn1 ? sext32(in_src1[31:0]) : {32'd0, in_src1[31:0]}) : in_src1;
    b_ext     = req_w ? (req_sgn2 ? sext32(in_src2[31:0]) : {32'd0, in_src2[31:0]}) : in_src2;
    a_neg     = req_sgn1 & a_ext[63];
    b_neg     = req_sgn2 & b_ext[63];
    a_mag     = a_neg ? -a_ext : a_ext;
    b_mag     = b_neg ? -b_ext : b_ext;
    req_neg   = req_rem ? a_neg : (a_neg ^ b_neg);
    src1_res  = req_w ? sext32(in_src1[31:0]) : in_src1;
    div_zero  = ~req_mul & (req_w ? (in_src2[31:0] == 32'd0) : (in_src2 == 64'd0));
    div_ovf   = ~req_mul & req_sgn1 &
                (req_w ? (in_src1[31:0] == 32'h8000_0000 && in_src2[31:0] == 32'hFFFF_FFFF)
                       : (in_src1 == {1'b1, 63'd0} && in_src2 == {64{1'b1}}));
    if (div_zero) spec_res = req_rem ? src1_res : {64{1'b1}};
    else          spec_res = req_rem ? 64'd0 : src1_res;
    accept    = in_valid & req_known & (state_q == ST_IDLE);
  end

`ifdef YSYX_25060170_MDU_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
  logic signed [127:0] fm_a, fm_b, fm_p;

  // Single-cycle product of the sign/zero-extended request operands.
  always_comb begin
    fm_a = req_sgn1 ? {{64{a_ext[63]}}, a_ext} : {64'd0, a_ext};
    fm_b = req_sgn2 ? {{64{b_ext[63]}}, b_ext} : {64'd0, b_ext};
    fm_p = fm_a * fm_b;
    case (in_op)
      MDU_MUL:  fast_res = fm_p[63:0];
      MDU_MULW: fast_res = sext32(fm_p[31:0]);
      default:  fast_res = fm_p[127:64];
    endcase
  end
`else
  localparam bit FastMul = 1'b0;
  assign fast_res = '0;
`endif

  ysyx_25060170_mdu_div_step u_div_step (
    .rem_i (hi_q),
    .quo_i (lo_q),
    .dvs_i (opnd_q),
    .rem_o (div_rem),
    .quo_o (div_quo)
  );

  // One datapath iteration: shift-add for multiply, restoring step for divide.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : 65'd0);
    if (op_is_mul(op_q)) begin
      step_hi = mul_sum[64:1];
      step_lo = {mul_sum[0], lo_q[63:1]};
    end else begin
      step_hi = div_rem;
      step_lo = div_quo;
    end
  end

  // Next-state logic; flush overrides accept and retire.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    op_d     = op_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_d  = in_op;
            neg_d = req_neg;
            if (div_zero || div_ovf) begin
              state_d  = ST_DONE;
              result_d = spec_res;
            end else if (FastMul && req_mul) begin
              state_d  = ST_DONE;
              result_d = fast_res;
            end else begin
              state_d = ST_BUSY;
              cnt_d   = req_w ? CNT_LOAD_W : CNT_LOAD_D;
              hi_d    = '0;
              if (req_mul) begin
                opnd_d = a_mag;
                lo_d   = b_mag;
              end else begin
                opnd_d = b_mag;
                lo_d   = req_w ? {a_mag[31:0], 32'd0} : a_mag;
              end
            end
          end
        end
        ST_BUSY: begin
          hi_d = step_hi;
          lo_d = step_lo;
          if (cnt_q == '0) begin
            state_d  = ST_DONE;
            result_d = fixup(op_q, neg_q, step_hi, step_lo);
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control state and visible result, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Datapath registers; only meaningful while BUSY, so no reset.
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    neg_q  <= neg_d;
    hi_q   <= hi_d;
    lo_q   <= lo_d;
    opnd_q <= opnd_d;
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign out_result = out_valid ? result_q : 64'd0;

endmodule

// File: tb/tb_ysyx_25060170_mdu_ctrl.sv
// Directed testbench for the RV64M multiply/divide sequencer.
module tb_ysyx_25060170_mdu_ctrl;
  import ysyx_25060170_mdu_ctrl_pkg::*;

`ifdef YSYX_25060170_MDU_FAST_MUL_EN
  localparam int MUL_LAT64 = 1;
  localparam int MUL_LATW  = 1;
`else
  localparam int MUL_LAT64 = 65;
  localparam int MUL_LATW  = 33;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [63:0] in_src1;
  logic [63:0] in_src2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic        busy;

  int errors = 0;
  int checks = 0;

  ysyx_25060170_mdu_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Present one request, wait for out_valid (bounded), report result and
  // latency counted from the accept edge (1 = valid in the following cycle).
  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic rdy, output logic [63:0] res, output int lat);
    in_op = op; in_src1 = a; in_src2 = b; out_ready = rdy; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_result;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_op = 4'd0; in_src1 = '0; in_src2 = '0;
    flush = 1'b0; out_ready = 1'b1;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 64'd0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b busy=%b res=%h need 0 0 0", out_valid, busy, out_result);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got in_ready=%b busy=%b need 1 0", in_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_div64();
    logic [63:0] res; int lat;
    issue(MDU_DIV, -64'sd20, 64'd3, 1'b1, res, lat);
    checks++;
    if (lat !== 65) begin errors++; $display("FAIL div_latency got %0d need 65", lat); end
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("FAIL div_result got %h need fffffffffffffffa", res); end
    retire();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL div_retire got valid=%b in_ready=%b need 0 1", out_valid, in_ready);
    end
    issue(MDU_REM, -64'sd20, 64'd3, 1'b1, res, lat);
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFE || lat !== 65) begin
      errors++; $display("FAIL rem_result got %h lat %0d need fffffffffffffffe lat 65", res, lat);
    end
    retire();
  endtask

  task automatic test_div_w();
    logic [63:0] res; int lat;
    issue(MDU_DIVUW, 64'd100, 64'd7, 1'b1, res, lat);
    checks++;
    if (res !== 64'd14 || lat !== 33) begin
      errors++; $display("FAIL divuw got %h lat %0d need e lat 33", res, lat);
    end
    retire();
    issue(MDU_REMW, 64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, res, lat);
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFF || lat !== 33) begin
      errors++; $display("FAIL remw got %h lat %0d need ffffffffffffffff lat 33", res, lat);
    end
    retire();
  endtask

  task automatic test_div_zero();
    logic [63:0] res; int lat;
    issue(MDU_DIVU, 64'h1234, 64'd0, 1'b1, res, lat);
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFF || lat !== 1) begin
      errors++; $display("FAIL divu_zero got %h lat %0d need ffffffffffffffff lat 1", res, lat);
    end
    retire();
    issue(MDU_REMU, 64'h1234, 64'd0, 1'b1, res, lat);
    checks++;
    if (res !== 64'h1234 || lat !== 1) begin
      errors++; $display("FAIL remu_zero got %h lat %0d need 1234 lat 1", res, lat);
    end
    retire();
  endtask

  task automatic test_overflow();
    logic [63:0] res; int lat;
    issue(MDU_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, res, lat);
    checks++;
    if (res !== 64'h8000_0000_0000_0000 || lat !== 1) begin
      errors++; $display("FAIL div_ovf got %h lat %0d need 8000000000000000 lat 1", res, lat);
    end
    retire();
    issue(MDU_DIVW, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, res, lat);
    checks++;
    if (res !== 64'hFFFF_FFFF_8000_0000 || lat !== 1) begin
      errors++; $display("FAIL divw_ovf got %h lat %0d need ffffffff80000000 lat 1", res, lat);
    end
    retire();
  endtask

  task automatic test_mul();
    logic [63:0] res; int lat;
    issue(MDU_MUL, 64'd7, 64'd6, 1'b1, res, lat);
    checks++;
    if (res !== 64'd42 || lat !== MUL_LAT64) begin
      errors++; $display("FAIL mul got %h lat %0d need 2a lat %0d", res, lat, MUL_LAT64);
    end
    retire();
    issue(MDU_MULH, -64'sd3, 64'd5, 1'b1, res, lat);
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL mulh got %h need ffffffffffffffff", res);
    end
    retire();
    issue(MDU_MULHSU, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, res, lat);
    checks++;
    if (res !== 64'd1) begin
      errors++; $display("FAIL mulhsu got %h need 1", res);
    end
    retire();
    issue(MDU_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, res, lat);
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFE || lat !== MUL_LAT64) begin
      errors++; $display("FAIL mulhu got %h lat %0d need fffffffffffffffe lat %0d", res, lat, MUL_LAT64);
    end
    retire();
  endtask

  task automatic test_mulw_hold();
    logic [63:0] res; int lat;
    issue(MDU_MULW, 64'h7FFF_FFFF, 64'd2, 1'b0, res, lat);
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFE || lat !== MUL_LATW) begin
      errors++; $display("FAIL mulw got %h lat %0d need fffffffffffffffe lat %0d", res, lat, MUL_LATW);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || out_result !== 64'hFFFF_FFFF_FFFF_FFFE) begin
        errors++;
        $display("FAIL mulw_hold cyc %0d got valid=%b busy=%b res=%h need 1 1 fffffffffffffffe", i, out_valid, busy, out_result);
      end
    end
    retire();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mulw_release got busy=%b in_ready=%b need 0 1", busy, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_op = MDU_DIVU; in_src1 = 64'h1234; in_src2 = 64'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_op = MDU_REMU;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_done got valid=%b in_ready=%b need 1 0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_idle got valid=%b in_ready=%b need 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 64'h1234) begin
      errors++; $display("FAIL b2b_second got valid=%b res=%h need 1 1234", out_valid, out_result);
    end
    retire();
  endtask

  task automatic test_invalid_op();
    in_op = 4'd13; in_src1 = 64'd5; in_src2 = 64'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_op = 4'd15;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL invalid_op got in_ready=%b busy=%b valid=%b need 1 0 0", in_ready, busy, out_valid);
    end
  endtask

  task automatic test_flush();
    logic [63:0] res; int lat; bit seen;
    // flush beats a simultaneous accept
    in_op = MDU_DIV; in_src1 = 64'd100; in_src2 = 64'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_accept got busy=%b valid=%b need 0 0", busy, out_valid);
    end
    // flush at BUSY cycle 10
    in_op = MDU_DIV; in_src1 = -64'sd20; in_src2 = 64'd3; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_busy got busy=%b in_ready=%b valid=%b need 0 1 0", busy, in_ready, out_valid);
    end
    seen = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (out_valid === 1'b1) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_result got out_valid seen=1 need 0"); end
    // flush while holding a result in DONE
    issue(MDU_DIVU, 64'h1234, 64'd0, 1'b0, res, lat);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_done got valid=%b busy=%b need 0 0", out_valid, busy);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    in_op = MDU_DIV; in_src1 = -64'sd20; in_src2 = 64'd3; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 64'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid got valid=%b busy=%b res=%h in_ready=%b need 0 0 0 1", out_valid, busy, out_result, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (out_valid === 1'b1 || busy === 1'b1) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_after got activity=%b in_ready=%b need 0 1", seen, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_div64();
    test_div_w();
    test_div_zero();
    test_overflow();
    test_mul();
    test_mulw_hold();
    test_back_to_back();
    test_invalid_op();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
